// File: rtl/log_buf_if.sv
// log_buf_if
//  Bundles the result-buffer traffic: the upstream sample/result strobe,
//  the downstream valid/ready drain and the occupancy/overflow status.
//  master : producer/consumer side (drives in_valid, log_value, out_ready)
//  slave  : log_result_buffer side (drives out_data, out_valid, count,
//           full, overflow and, with LOG_BUF_STATS_EN, drop_cnt)
//  Optional feature macro: LOG_BUF_STATS_EN adds the drop_cnt status bus.
interface log_buf_if #(
  parameter int DATA_W = 33,
  parameter int ADDR_W = 3
);
  logic              in_valid;
  logic [DATA_W-1:0] log_value;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              overflow;
`ifdef LOG_BUF_STATS_EN
  logic [7:0]        drop_cnt;

  modport master (
    output in_valid, log_value, out_ready,
    input  out_data, out_valid, count, full, overflow, drop_cnt
  );
  modport slave (
    input  in_valid, log_value, out_ready,
    output out_data, out_valid, count, full, overflow, drop_cnt
  );
`else
  modport master (
    output in_valid, log_value, out_ready,
    input  out_data, out_valid, count, full, overflow
  );
  modport slave (
    input  in_valid, log_value, out_ready,
    output out_data, out_valid, count, full, overflow
  );
`endif
endinterface

// File: rtl/log_result_buffer.sv
// log_result_buffer
//  Downstream stage of the log pipeline. A token delay line follows every
//  accepted sample through the CORDIC/AU latency; when the token emerges the
//  matching log_value is captured into a first-word-fall-through FIFO that a
//  valid/ready consumer drains. A capture that finds the FIFO full with no
//  simultaneous pop is dropped and sets the sticky overflow flag.
//  Ports:
//    clk    rising-edge clock
//    reset  synchronous, active-high; clears delay line, pointers, count and
//           status flags (FIFO storage itself is not cleared)
//    bus    log_buf_if.slave: in_valid, log_value, out_ready (inputs);
//           out_data, out_valid, count, full, overflow[, drop_cnt] (outputs)
//  Optional feature macro: LOG_BUF_STATS_EN adds a saturating 8-bit
//  dropped-result counter on bus.drop_cnt.
module log_result_buffer #(
  parameter int DATA_W   = 33,
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = 3,
  parameter int PIPE_LAT = 18
) (
  input  logic     clk,
  input  logic     reset,
  log_buf_if.slave bus
);

  logic [PIPE_LAT-1:0] vld_dly;
  logic                cap;
  logic                pop;
  logic                push_ok;
  logic                drop;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic [ADDR_W:0]     count;
  logic                overflow;
  logic                full;
  logic                out_valid;

  // DEPTH is a power of two, so natural ADDR_W-bit rollover is the modulo wrap.
  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    return p + ADDR_W'(1);
  endfunction

  // ---- token delay line: bit k set means a sample entered k+1 cycles ago
  always_ff @(posedge clk) begin
    if (reset) vld_dly <= '0;
    else       vld_dly <= (vld_dly << 1) | PIPE_LAT'(bus.in_valid);
  end

  assign cap = vld_dly[PIPE_LAT-1];

  // ---- FIFO stage: capture, accept/reject decision
  // Status is a pure function of the registered count, so out_ready never
  // reaches out_valid combinationally.
  assign out_valid = (count != '0);
  assign full      = (count == (ADDR_W+1)'(DEPTH));
  assign pop       = out_valid && bus.out_ready;
  // A full FIFO can still take the capture when the head leaves on the same edge.
  assign push_ok   = cap && (!full || pop);
  assign drop      = cap && full && !pop;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= bus.log_value;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)     rd_ptr <= ptr_inc(rd_ptr);
      case ({push_ok, pop})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

`ifdef LOG_BUF_STATS_EN
  logic [7:0] drop_cnt;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset)     drop_cnt <= '0;
    else if (drop) drop_cnt <= sat_inc8(drop_cnt);
  end

  assign bus.drop_cnt = drop_cnt;
`endif

  // ---- output stage: FWFT head, no read latency
  assign bus.out_data  = mem[rd_ptr];
  assign bus.out_valid = out_valid;
  assign bus.count     = count;
  assign bus.full      = full;
  assign bus.overflow  = overflow;

endmodule

// File: tb/tb_log_result_buffer.sv
// tb_log_result_buffer
//  Directed bench for log_result_buffer (DATA_W=33, DEPTH=8, PIPE_LAT=18).
//  Inputs change 1 time unit after the rising edge; outputs are sampled at
//  the same point, i.e. they show the state produced by the preceding edge.
module tb_log_result_buffer;
  localparam int DATA_W   = 33;
  localparam int DEPTH    = 8;
  localparam int ADDR_W   = 3;
  localparam int PIPE_LAT = 18;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  log_buf_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  log_result_buffer #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue n back-to-back samples and present their results (base, base+1, ...)
  // on log_value exactly PIPE_LAT cycles after each in_valid. With rdy=1 the
  // consumer drains continuously and every popped word is checked in order.
  task automatic run_stream(input int n, input logic [32:0] base, input logic rdy);
    int popped = 0;
    for (int c = 0; c < n + PIPE_LAT; c++) begin
      bus.in_valid  = (c < n);
      bus.log_value = (c >= PIPE_LAT) ? base + 33'(c - PIPE_LAT) : '0;
      bus.out_ready = rdy;
      if (rdy) begin
        if (bus.out_valid) begin
          check("stream_data", 64'(bus.out_data), 64'(base + 33'(popped)));
          popped++;
        end
        check("stream_count_le1", 64'(bus.count <= 4'd1), 64'd1);
      end
      step();
    end
    bus.in_valid  = 1'b0;
    bus.log_value = '0;
    if (rdy) begin
      for (int k = 0; k < 4; k++) begin
        if (bus.out_valid) begin
          check("stream_data", 64'(bus.out_data), 64'(base + 33'(popped)));
          popped++;
        end
        step();
      end
      check("stream_total", 64'(popped), 64'(n));
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.log_value = '0;
    bus.out_ready = 1'b0;
    step();
    step();

    // Reset state
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_count",     64'(bus.count),     64'd0);
    check("rst_full",      64'(bus.full),      64'd0);
    check("rst_overflow",  64'(bus.overflow),  64'd0);
`ifdef LOG_BUF_STATS_EN
    check("rst_drop_cnt",  64'(bus.drop_cnt),  64'd0);
`endif
    reset = 1'b0;

    // Single sample: in_valid at t0, result at t0+18, visible at t0+19
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (PIPE_LAT - 1) step();
    bus.log_value = 33'h0_0000_1234;
    check("single_not_yet", 64'(bus.out_valid), 64'd0);
    step();
    bus.log_value = '0;
    check("single_valid", 64'(bus.out_valid), 64'd1);
    check("single_data",  64'(bus.out_data),  64'h1234);
    check("single_count", 64'(bus.count),     64'd1);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("single_drained", 64'(bus.count),     64'd0);
    check("single_empty",   64'(bus.out_valid), 64'd0);

    // Burst of 8 with consumer stalled, then drain in order
    run_stream(8, 33'd1, 1'b0);
    check("burst_count",    64'(bus.count),    64'd8);
    check("burst_full",     64'(bus.full),     64'd1);
    check("burst_overflow", 64'(bus.overflow), 64'd0);
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check("burst_valid", 64'(bus.out_valid), 64'd1);
      check("burst_data",  64'(bus.out_data),  64'(i));
      step();
    end
    bus.out_ready = 1'b0;
    check("burst_count_end", 64'(bus.count), 64'd0);
    check("burst_full_end",  64'(bus.full),  64'd0);

    // Full FIFO, push of 0x55 on the same cycle as a pop
    run_stream(8, 33'h21, 1'b0);
    check("fs_full", 64'(bus.full), 64'd1);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (PIPE_LAT - 1) step();
    bus.log_value = 33'h55;
    bus.out_ready = 1'b1;
    check("fs_full_at_push", 64'(bus.full),     64'd1);
    check("fs_head",         64'(bus.out_data), 64'h21);
    step();
    bus.log_value = '0;
    check("fs_count",    64'(bus.count),    64'd8);
    check("fs_overflow", 64'(bus.overflow), 64'd0);
    for (int i = 0; i < 8; i++) begin
      check("fs_data", 64'(bus.out_data), (i < 7) ? 64'(8'h22 + i) : 64'h55);
      step();
    end
    bus.out_ready = 1'b0;
    check("fs_count_end", 64'(bus.count), 64'd0);

    // Wrap: 20 results streamed through with consumer always ready
    run_stream(20, 33'h1_0000_0100, 1'b1);
    check("wrap_count_end", 64'(bus.count),    64'd0);
    check("wrap_overflow",  64'(bus.overflow), 64'd0);

    // Overflow: 10 results into a stalled FIFO, last two lost
    run_stream(10, 33'd1, 1'b0);
    check("ovf_count",    64'(bus.count),    64'd8);
    check("ovf_full",     64'(bus.full),     64'd1);
    check("ovf_overflow", 64'(bus.overflow), 64'd1);
`ifdef LOG_BUF_STATS_EN
    check("ovf_drop_cnt", 64'(bus.drop_cnt), 64'd2);
`endif
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check("ovf_data", 64'(bus.out_data), 64'(i));
      step();
    end
    bus.out_ready = 1'b0;
    check("ovf_empty",        64'(bus.out_valid), 64'd0);
    check("ovf_sticky",       64'(bus.overflow),  64'd1);

    // Reset mid-flight: 3 samples, reset at t0+5, nothing ever emerges
    bus.in_valid = 1'b1;
    repeat (3) step();
    bus.in_valid = 1'b0;
    repeat (2) step();
    do_reset();
    check("rmf_overflow", 64'(bus.overflow), 64'd0);
    bus.log_value = 33'h1_dead_beef;
    for (int i = 0; i < 25; i++) begin
      check("rmf_no_valid", 64'(bus.out_valid), 64'd0);
      step();
    end
    bus.log_value = '0;
    check("rmf_count",    64'(bus.count),    64'd0);
    check("rmf_overflow_end", 64'(bus.overflow), 64'd0);

`ifdef LOG_BUF_STATS_EN
    // Saturation: 300 drops on top of a full FIFO
    run_stream(308, 33'd1, 1'b0);
    check("sat_drop_cnt", 64'(bus.drop_cnt), 64'd255);
    check("sat_overflow", 64'(bus.overflow), 64'd1);
    check("sat_count",    64'(bus.count),    64'd8);
    do_reset();
    check("sat_drop_rst", 64'(bus.drop_cnt), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
